// File: rtl/pipeline_controller.sv
// rtl/pipeline_controller.sv - pipeline stall/flush controller with multi-cycle wait and watchdog
module pipeline_controller #(
    parameter int MC_TIMEOUT = 64
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        lu_haz_sig_i,
    input  logic        branch_taken_i,
    input  logic        imem_busy_i,
    input  logic        dmem_busy_i,
    input  logic        mc_start_i,
    input  logic        mc_done_i,
    output logic        pc_stall_o,
    output logic        if_id_stall_o,
    output logic        id_ex_stall_o,
    output logic        ex_mem_stall_o,
    output logic        mem_wb_stall_o,
    output logic        if_id_flush_o,
    output logic        id_ex_flush_o,
    output logic        ex_mem_flush_o,
    output logic [1:0]  state_o,
    output logic        mc_error_o,
    output logic [31:0] stall_cycles_o,
    output logic [15:0] flush_count_o
);

    localparam logic [1:0] ST_RUN  = 2'b00;
    localparam logic [1:0] ST_WAIT = 2'b01;

    logic [1:0]  state_q, state_d;
    logic [7:0]  wd_q, wd_d;
    logic        err_q, err_d;
    logic [31:0] stall_q, stall_d;
    logic [15:0] flush_q, flush_d;

    logic in_wait, freeze, accept, fire, mc_hold, branch_act, haz_act, imem_act;

    // Condition decode, highest priority first. A data-memory stall freezes
    // everything; a pending multi-cycle op (waiting, or being issued without
    // an immediate result) outranks the front-end conditions.
    assign freeze     = dmem_busy_i;
    assign in_wait    = (state_q == ST_WAIT);
    assign accept     = in_wait & mc_done_i & ~freeze;
    assign fire       = in_wait & ~accept & (wd_q == 8'(MC_TIMEOUT - 1));
    assign mc_hold    = ~freeze & ~mc_done_i & (in_wait | mc_start_i);
    assign branch_act = ~freeze & ~mc_hold & branch_taken_i;
    assign haz_act    = ~freeze & ~mc_hold & ~branch_taken_i & lu_haz_sig_i;
    assign imem_act   = ~freeze & ~mc_hold & ~branch_taken_i & ~lu_haz_sig_i & imem_busy_i;

    // State register and all registered bookkeeping
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_RUN;
            wd_q    <= '0;
            err_q   <= 1'b0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            wd_q    <= wd_d;
            err_q   <= err_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    // Next state: issue enters MC_WAIT unless the result is already there;
    // acceptance or watchdog expiry returns to RUN
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:  if (~freeze & mc_start_i & ~mc_done_i) state_d = ST_WAIT;
            ST_WAIT: if (accept | fire) state_d = ST_RUN;
            default: state_d = ST_RUN;
        endcase
    end

    // Watchdog counts every MC_WAIT cycle (frozen ones too); perf counters saturate
    always_comb begin
        wd_d    = '0;
        err_d   = err_q | fire;
        stall_d = stall_q;
        flush_d = flush_q;
        if (in_wait & ~accept & ~fire) wd_d = wd_q + 8'd1;
        if (pc_stall_o && (stall_q != '1)) stall_d = stall_q + 32'd1;
        if (branch_act && (flush_q != '1)) flush_d = flush_q + 16'd1;
    end

    // Stall/flush outputs, forced quiet while reset is held
    always_comb begin
        pc_stall_o     = 1'b0;
        if_id_stall_o  = 1'b0;
        id_ex_stall_o  = 1'b0;
        ex_mem_stall_o = 1'b0;
        mem_wb_stall_o = 1'b0;
        if_id_flush_o  = 1'b0;
        id_ex_flush_o  = 1'b0;
        ex_mem_flush_o = 1'b0;
        if (!rst_i) begin
            if (freeze) begin
                pc_stall_o     = 1'b1;
                if_id_stall_o  = 1'b1;
                id_ex_stall_o  = 1'b1;
                ex_mem_stall_o = 1'b1;
                mem_wb_stall_o = 1'b1;
            end else if (mc_hold) begin
                pc_stall_o     = 1'b1;
                if_id_stall_o  = 1'b1;
                id_ex_stall_o  = 1'b1;
                ex_mem_flush_o = 1'b1;
            end else if (branch_act) begin
                if_id_flush_o  = 1'b1;
                id_ex_flush_o  = 1'b1;
            end else if (haz_act) begin
                pc_stall_o     = 1'b1;
                if_id_stall_o  = 1'b1;
                id_ex_flush_o  = 1'b1;
            end else if (imem_act) begin
                pc_stall_o     = 1'b1;
                if_id_flush_o  = 1'b1;
            end
        end
    end

    assign state_o        = state_q;
    assign mc_error_o     = err_q;
    assign stall_cycles_o = stall_q;
    assign flush_count_o  = flush_q;

endmodule

// File: tb/tb_pipeline_controller.sv
// tb/tb_pipeline_controller.sv - randomized and directed bench for pipeline_controller
module tb_pipeline_controller;

    localparam int TA = 8;
    localparam int TB = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic lu = 1'b0, br = 1'b0, im = 1'b0, dm = 1'b0, st = 1'b0, dn = 1'b0;

    logic a_pc, a_ifs, a_ids, a_ems, a_mws, a_iff, a_idf, a_emf, a_err;
    logic [1:0]  a_state;
    logic [31:0] a_sc;
    logic [15:0] a_fc;
    logic b_pc, b_ifs, b_ids, b_ems, b_mws, b_iff, b_idf, b_emf, b_err;
    logic [1:0]  b_state;
    logic [31:0] b_sc;
    logic [15:0] b_fc;

    wire [7:0] a_vec = {a_pc, a_ifs, a_ids, a_ems, a_mws, a_iff, a_idf, a_emf};
    wire [7:0] b_vec = {b_pc, b_ifs, b_ids, b_ems, b_mws, b_iff, b_idf, b_emf};

    pipeline_controller #(.MC_TIMEOUT(TA)) dut_a (
        .clk_i(clk), .rst_i(rst), .lu_haz_sig_i(lu), .branch_taken_i(br),
        .imem_busy_i(im), .dmem_busy_i(dm), .mc_start_i(st), .mc_done_i(dn),
        .pc_stall_o(a_pc), .if_id_stall_o(a_ifs), .id_ex_stall_o(a_ids),
        .ex_mem_stall_o(a_ems), .mem_wb_stall_o(a_mws), .if_id_flush_o(a_iff),
        .id_ex_flush_o(a_idf), .ex_mem_flush_o(a_emf), .state_o(a_state),
        .mc_error_o(a_err), .stall_cycles_o(a_sc), .flush_count_o(a_fc)
    );

    pipeline_controller #(.MC_TIMEOUT(TB)) dut_b (
        .clk_i(clk), .rst_i(rst), .lu_haz_sig_i(lu), .branch_taken_i(br),
        .imem_busy_i(im), .dmem_busy_i(dm), .mc_start_i(st), .mc_done_i(dn),
        .pc_stall_o(b_pc), .if_id_stall_o(b_ifs), .id_ex_stall_o(b_ids),
        .ex_mem_stall_o(b_ems), .mem_wb_stall_o(b_mws), .if_id_flush_o(b_iff),
        .id_ex_flush_o(b_idf), .ex_mem_flush_o(b_emf), .state_o(b_state),
        .mc_error_o(b_err), .stall_cycles_o(b_sc), .flush_count_o(b_fc)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model for dut_a: is an op outstanding, how long has it waited
    bit       m_wait;
    int       m_cnt;
    bit       m_err;
    longint   m_stall;
    int       m_flush;
    logic [7:0] e_out;
    bit       e_br;
    logic [7:0] b_snap;
    logic [1:0] b_snap_state;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Expected outputs {pc,ifid_s,idex_s,exmem_s,memwb_s,ifid_f,idex_f,exmem_f}
    task automatic calc();
        e_out = 8'h00;
        e_br  = 1'b0;
        if (rst)                            e_out = 8'b11111_000;
        if (rst)                            e_out = 8'h00;
        else if (dm)                        e_out = 8'b11111_000;
        else if (!dn && (m_wait || st))     e_out = 8'b11100_001;
        else if (br) begin                  e_out = 8'b00000_110; e_br = 1'b1; end
        else if (lu)                        e_out = 8'b11000_010;
        else if (im)                        e_out = 8'b10000_100;
    endtask

    task automatic model_clock();
        if (e_out[7] && m_stall < 64'hFFFF_FFFF) m_stall++;
        if (e_br && m_flush < 65535) m_flush++;
        if (m_wait) begin
            if (dn && !dm) begin
                m_wait = 1'b0;
                m_cnt  = 0;
            end else begin
                m_cnt++;
                if (m_cnt == TA) begin
                    m_wait = 1'b0;
                    m_cnt  = 0;
                    m_err  = 1'b1;
                end
            end
        end else if (!dm && st && !dn) begin
            m_wait = 1'b1;
            m_cnt  = 0;
        end
    endtask

    task automatic model_reset();
        m_wait = 0; m_cnt = 0; m_err = 0; m_stall = 0; m_flush = 0;
    endtask

    task automatic cyc(input string tag, input bit ilu, input bit ibr, input bit iim,
                       input bit idm, input bit ist, input bit idn, input bit check = 1'b1);
        @(negedge clk);
        lu = ilu; br = ibr; im = iim; dm = idm; st = ist; dn = idn;
        #1;
        calc();
        b_snap = b_vec;
        b_snap_state = b_state;
        if (check) chk({tag, "_out"}, a_vec, e_out);
        @(posedge clk);
        model_clock();
        #1;
        if (check) begin
            chk({tag, "_state"}, a_state, {1'b0, m_wait});
            chk({tag, "_err"}, a_err, m_err);
            chk({tag, "_stallcnt"}, a_sc, m_stall);
            chk({tag, "_flushcnt"}, a_fc, m_flush);
        end
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        lu = 1; br = 0; im = 1; dm = 0; st = 0; dn = 0;
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk({tag, "_rst_state"}, a_state, 2'b00);
        chk({tag, "_rst_err"}, a_err, 1'b0);
        chk({tag, "_rst_out"}, a_vec, 8'h00);
        chk({tag, "_rst_cnt"}, {a_sc, a_fc}, 48'h0);
        @(negedge clk);
        rst = 1'b0;
        lu = 0; im = 0;
    endtask

    initial begin
        model_reset();
        lu = 1'b1;
        #1;
        chk("init_out_gated", a_vec, 8'h00);
        chk("init_state", a_state, 2'b00);
        chk("init_err", {a_err, b_err}, 2'b00);
        chk("init_cnt", {a_sc, a_fc}, 48'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        lu  = 1'b0;

        // Single load-use cycle
        cyc("idle", 0, 0, 0, 0, 0, 0);
        cyc("luhaz", 1, 0, 0, 0, 0, 0);
        chk("luhaz_stallcnt_is1", a_sc, 32'd1);
        cyc("idle2", 0, 0, 0, 0, 0, 0);

        // Multi-cycle op: start at 0, done at 5
        cyc("mc_c0", 0, 0, 0, 0, 1, 0);
        for (int i = 1; i <= 4; i++) cyc("mc_wait", 0, 0, 0, 0, 0, 0);
        cyc("mc_c5", 0, 0, 0, 0, 0, 1);
        chk("mc_run_c6", a_state, 2'b00);

        // Completion arriving while frozen is deferred
        cyc("fz_st", 0, 0, 0, 0, 1, 0);
        cyc("fz_w1", 0, 0, 0, 0, 0, 0);
        cyc("fz_done_busy", 0, 0, 0, 1, 0, 1);
        chk("fz_still_wait", a_state, 2'b01);
        cyc("fz_done_busy2", 1, 1, 0, 1, 0, 1);
        cyc("fz_accept", 0, 0, 0, 0, 0, 1);

        // Branch beats hazard and imem
        cyc("br_all", 1, 1, 1, 0, 0, 0);
        cyc("imem", 0, 0, 1, 0, 0, 0);
        // Zero-wait op with a branch in the same cycle
        cyc("zero_wait", 0, 1, 0, 0, 1, 1);
        cyc("freeze_start", 0, 0, 0, 1, 1, 0);

        // Watchdog on the MC_TIMEOUT=4 instance
        do_reset("wd");
        cyc("wd_start", 0, 0, 0, 0, 1, 0);
        chk("wd_b_state0", b_state, 2'b01);
        for (int i = 1; i <= 3; i++) begin
            cyc("wd_wait", 0, 0, 0, 0, 0, 0);
            chk("wd_b_state_waiting", b_state, 2'b01);
            chk("wd_b_err_low", b_err, 1'b0);
        end
        cyc("wd_fire", 0, 0, 0, 0, 0, 0);
        chk("wd_b_fire_out", b_snap, 8'b11100_001);
        chk("wd_b_fire_state", b_snap_state, 2'b01);
        chk("wd_b_after_state", b_state, 2'b00);
        chk("wd_b_after_err", b_err, 1'b1);
        for (int i = 0; i < 6; i++) cyc("wd_a_run", 0, 0, 0, 0, 0, 0);
        chk("wd_a_err", a_err, 1'b1);
        chk("wd_b_sticky", b_err, 1'b1);

        // Asynchronous reset in the middle of a wait
        cyc("ar_start", 0, 0, 0, 0, 1, 0);
        cyc("ar_wait", 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk("ar_state", a_state, 2'b00);
        chk("ar_err", {a_err, b_err}, 2'b00);
        chk("ar_out", a_vec, 8'h00);
        @(negedge clk);
        rst = 1'b0;

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            cyc("rnd", ($urandom_range(99) < 25), ($urandom_range(99) < 15),
                ($urandom_range(99) < 25), ($urandom_range(99) < 20),
                ($urandom_range(99) < 15), ($urandom_range(99) < 25));
        end

        // Flush counter saturation
        do_reset("sat");
        for (int i = 0; i < 65535; i++) cyc("sat_fill", 0, 1, 0, 0, 0, 0, 1'b0);
        chk("sat_full", a_fc, 16'hFFFF);
        cyc("sat_more", 0, 1, 0, 0, 0, 0);
        chk("sat_hold", a_fc, 16'hFFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
